// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned SEL_W    = 2;
   localparam int unsigned IMM_W    = 8;
   localparam int unsigned ALU_OP_W = 2;

   localparam int unsigned OPCODE_LSB = 12;
   localparam int unsigned SEL_LSB    = 10;
   localparam int unsigned RSVD_LSB   = 8;
   localparam int unsigned IMM_LSB    = 0;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_WRITEBACK,
      ST_HALT
   } ctrl_state_t;

   localparam logic [OPCODE_W-1:0] OP_NOP   = 4'd0;
   localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'd1;
   localparam logic [OPCODE_W-1:0] OP_ADD   = 4'd2;
   localparam logic [OPCODE_W-1:0] OP_SUB   = 4'd3;
   localparam logic [OPCODE_W-1:0] OP_STORE = 4'd4;
   localparam logic [OPCODE_W-1:0] OP_JMP   = 4'd5;
   localparam logic [OPCODE_W-1:0] OP_JZ    = 4'd6;
   localparam logic [OPCODE_W-1:0] OP_HALT  = 4'd7;

   localparam logic [ALU_OP_W-1:0] ALU_PASS = 2'b00;
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 2'b01;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 2'b10;

   // Field order mirrors the instruction word, MSB first.
   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [SEL_W-1:0]    sel;
      logic [1:0]          rsvd;
      logic [IMM_W-1:0]    imm;
   } instr_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: ALU operation and instruction-class flags.
module instr_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output logic [ALU_OP_W-1:0] alu_op_c,
   output logic                alu_write_c,
   output logic                store_c,
   output logic                jump_c,
   output logic                halt_c
);

   always_comb begin
      alu_op_c    = ALU_PASS;
      alu_write_c = 1'b0;
      store_c     = 1'b0;
      jump_c      = 1'b0;
      halt_c      = 1'b0;
      unique case (opcode)
         OP_LOAD: alu_write_c = 1'b1;
         OP_ADD: begin
            alu_op_c    = ALU_ADD;
            alu_write_c = 1'b1;
         end
         OP_SUB: begin
            alu_op_c    = ALU_SUB;
            alu_write_c = 1'b1;
         end
         OP_STORE: store_c = 1'b1;
         OP_JMP,
         OP_JZ:    jump_c  = 1'b1;
         OP_HALT:  halt_c  = 1'b1;
         // NOP and opcodes 8-15 behave as NOP
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM: fetch over valid/ready, decode, drive mux/ALU/strobes, own the PC.
module cpu_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned INSTR_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   instr_valid,
   input  logic [INSTR_WIDTH-1:0] instr_data,
   output logic                   instr_ready,
   input  logic                   zero_flag,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic [SEL_W-1:0]       mux_sel,
   output logic [IMM_W-1:0]       imm,
   output logic [ALU_OP_W-1:0]    alu_op,
   output logic                   acc_we,
   output logic                   mem_we,
   output logic                   halted
);

   ctrl_state_t state_q, state_d;
   instr_t      ir_q, ir_d;

   logic [ADDR_WIDTH-1:0] pc_d;
   logic [SEL_W-1:0]      mux_sel_d;
   logic [IMM_W-1:0]      imm_d;
   logic [ALU_OP_W-1:0]   alu_op_d;
   logic                  instr_ready_d, acc_we_d, mem_we_d, halted_d;

   logic [ALU_OP_W-1:0] dec_alu_op_c;
   logic                dec_alu_write_c, dec_store_c, dec_jump_c, dec_halt_c;
   logic                unused_rsvd_c;

   assign unused_rsvd_c = ^ir_q.rsvd;

   instr_decode u_decode (
      .opcode      (ir_q.opcode),
      .alu_op_c    (dec_alu_op_c),
      .alu_write_c (dec_alu_write_c),
      .store_c     (dec_store_c),
      .jump_c      (dec_jump_c),
      .halt_c      (dec_halt_c)
   );

   // Next-state, datapath-register and strobe logic
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      pc_d      = pc;
      mux_sel_d = mux_sel;
      imm_d     = imm;
      alu_op_d  = alu_op;
      unique case (state_q)
         ST_FETCH: begin
            if (instr_valid) begin
               ir_d    = instr_t'(instr_data);
               pc_d    = pc + ADDR_WIDTH'(1);
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            mux_sel_d = ir_q.sel;
            imm_d     = ir_q.imm;
            alu_op_d  = dec_alu_op_c;
            state_d   = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (dec_jump_c && ((ir_q.opcode == OP_JMP) || zero_flag)) begin
               pc_d = ADDR_WIDTH'(ir_q.imm);
            end
            if (dec_halt_c) begin
               state_d = ST_HALT;
            end else if (dec_alu_write_c) begin
               state_d = ST_WRITEBACK;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_WRITEBACK: state_d = ST_FETCH;
         ST_HALT:      state_d = ST_HALT;
         default:      state_d = ST_FETCH;
      endcase

      // Strobes are flopped decodes of the state being entered, so they track the state register glitch-free.
      instr_ready_d = (state_d == ST_FETCH);
      acc_we_d      = (state_d == ST_WRITEBACK);
      mem_we_d      = (state_d == ST_EXECUTE) && dec_store_c;
      halted_d      = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FETCH;
         ir_q        <= '0;
         pc          <= '0;
         mux_sel     <= '0;
         imm         <= '0;
         alu_op      <= ALU_PASS;
         instr_ready <= 1'b1;
         acc_we      <= 1'b0;
         mem_we      <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         pc          <= pc_d;
         mux_sel     <= mux_sel_d;
         imm         <= imm_d;
         alu_op      <= alu_op_d;
         instr_ready <= instr_ready_d;
         acc_we      <= acc_we_d;
         mem_we      <= mem_we_d;
         halted      <= halted_d;
      end
   end

endmodule
